go_cursor_input: RTL and testbench
==================================

// Module: go_cursor_input
// PURPOSE
//  Front-end driver for the 19x19 Go board core: turns five raw push-buttons into the core's one-hot x/y
//  cursor buses and a clean place strobe. Provides synchronisation, debounce, auto-repeat and a place-pulse
//  sequencer. The cursor is frozen around each strobe so the board samples a stable coordinate.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable synced samples needed to accept a button change (>=1)
//  REPEAT_DELAY     16  cycles a held direction must stay pressed, after its first move, before auto-repeat
//  REPEAT_RATE      4   cycles between auto-repeat moves (>=1)
//  PLACE_HOLD       2   cycles place is driven high, and minimum low gap after it (>=1)
//  START_X          9   column index loaded on reset (0..18)
//  START_Y          9   row index loaded on reset (0..18)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  btn_up     in   1   raw, async; decrements row index (toward row0)
//  btn_down   in   1   raw, async; increments row index
//  btn_left   in   1   raw, async; decrements column index (toward LSB)
//  btn_right  in   1   raw, async; increments column index
//  btn_place  in   1   raw, async; requests a stone placement
//  x          out  19  one-hot column to board, bit i = column i
//  y          out  19  one-hot row to board, bit j = row j
//  place      out  1   placement strobe to board (board edge-detects it)
//  cur_col    out  5   binary column index (0..18)
//  cur_row    out  5   binary row index (0..18)
//  busy       out  1   high while place sequencer is not IDLE
// BEHAVIOUR
//  Reset (async assert, sync-free release):
//   - cur_col=START_X, cur_row=START_Y; x=1<<START_X, y=1<<START_Y.
//   - place=0, busy=0, all debounced states 0, repeat counters 0, sequencer IDLE.
//   - Reset mid-strobe drops place in the same instant.
//  Input conditioning:
//   - Each button passes through a 2-FF synchroniser, then a per-button counter.
//   - The debounced level flips after DEBOUNCE_CYCLES consecutive synced samples differing from it.
//   - Any matching sample clears that button's counter.
//  Movement:
//   - Debounced rising edge of a direction -> one step, registered on the next edge.
//   - Raw high first sampled at edge N gives the first x/y change at edge N+DEBOUNCE_CYCLES+2.
//   - While held: next step REPEAT_DELAY cycles after the first step, then one step every REPEAT_RATE cycles.
//   - Release stops repeat immediately and resets the repeat counter.
//   - Axes are independent; diagonal holds move both axes in the same cycle.
//   - up+down both debounced high -> no vertical move; same for left+right (counters held at 0).
//   - x/y are always exactly one-hot and are registered, not decoded combinationally from indices.
//  Edge handling: governed by GO_CURSOR_WRAP_EN (see CONFIGURATION).
//  Place sequencer, states IDLE -> STROBE -> GAP -> IDLE:
//   - IDLE: debounced rising edge of btn_place -> STROBE.
//   - STROBE: place=1 for exactly PLACE_HOLD cycles -> GAP.
//   - GAP: place=0 for >=PLACE_HOLD cycles, and until debounced btn_place is low -> IDLE.
//   - busy=1 in STROBE and GAP. One strobe per physical press; no auto-repeat on place.
//   - While busy, direction moves are suppressed and repeat counters hold at 0.
//   - A direction edge on the same cycle as the place edge is discarded.
//   - x/y never change while place=1.
// CONFIGURATION
//  GO_CURSOR_WRAP_EN defined:
//   - stepping past 0 goes to 18, past 18 goes to 0 (per axis); one-hot is a rotate.
//  GO_CURSOR_WRAP_EN undefined:
//   - index saturates at 0/18; a blocked step leaves x/y unchanged;
//   - repeat continues counting but produces no change.
// TESTING
//  - Reset: rst_n=0 -> x=0x00200, y=0x00200, cur_col=9, cur_row=9, place=0, busy=0.
//  - Bounce: btn_right toggles every cycle for 10 cycles, then high 1 cycle, then low -> cur_col stays 9.
//  - Clean press: btn_right high 1 cycle longer than DEBOUNCE_CYCLES+2 -> cur_col=10, x=0x00400, exactly
//    one step.
//  - Repeat: btn_down held 40 cycles after first step (defaults) -> steps at +0,+16,+20,+24,+28,+32,+36,+40;
//    cur_row=17.
//  - Edge: from col 0, press left -> wrap build: cur_col=18, x=0x40000; saturate build: cur_col=0.
//  - Place: btn_place held 30 cycles with btn_up pressed mid-strobe -> single 2-cycle place pulse; y unchanged
//    during busy; busy stays high until the place release debounces; rst_n pulse during STROBE -> place=0
//    at once.

Source files
------------

// File: rtl/go_cursor_input.sv
// go_cursor_input: push-button front end for the 19x19 Go board core.
// Each raw button is synchronised and debounced. Directions move a registered
// one-hot cursor, with auto-repeat while a direction is held. A sequencer turns
// each press of btn_place into one strobe and holds the cursor still around it.
// Optional feature: define GO_CURSOR_WRAP_EN to wrap at the board edges.
// Without it, each index saturates at 0 and 18.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   btn_up/down/left/right/place        raw asynchronous buttons
//   x, y                                one-hot column / row to the board
//   place                               placement strobe (board edge-detects it)
//   cur_col, cur_row                    binary cursor indices (0..18)
//   busy                                place sequencer not idle
module go_cursor_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_RATE     = 4,
  parameter int unsigned PLACE_HOLD      = 2,
  parameter int unsigned START_X         = 9,
  parameter int unsigned START_Y         = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_place,
  output logic [18:0] x,
  output logic [18:0] y,
  output logic        place,
  output logic [4:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);

  localparam int unsigned N       = 19;
  localparam int unsigned IW      = 5;
  localparam int unsigned NB      = 5;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam int unsigned PH_W    = (PLACE_HOLD > 1) ? $clog2(PLACE_HOLD) : 1;
  localparam int unsigned B_UP    = 0;
  localparam int unsigned B_DOWN  = 1;
  localparam int unsigned B_LEFT  = 2;
  localparam int unsigned B_RIGHT = 3;
  localparam int unsigned B_PLACE = 4;

`ifdef GO_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_GAP    = 2'd2
  } seq_state_e;

  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync1, sync2, deb, deb_prev, rise;
  logic [DB_W-1:0] db_cnt [NB];

  assign raw  = {btn_place, btn_right, btn_left, btn_down, btn_up};
  assign rise = deb & ~deb_prev;

  // Two-flop synchroniser followed by a per-button debounce counter.
  // The counter clears on any sample that agrees with the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Place sequencer: state register.
  seq_state_e      state, state_nxt;
  logic [PH_W-1:0] ph_cnt, ph_cnt_nxt;
  logic            place_nxt, busy_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ph_cnt <= '0;
      place  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ph_cnt <= ph_cnt_nxt;
      place  <= place_nxt;
      busy   <= busy_nxt;
    end
  end

  // Place sequencer: next state. GAP saturates its counter until place is released.
  always_comb begin
    state_nxt  = state;
    ph_cnt_nxt = ph_cnt;
    case (state)
      S_IDLE: begin
        ph_cnt_nxt = '0;
        if (rise[B_PLACE]) state_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (ph_cnt == PH_W'(PLACE_HOLD - 1)) begin
          state_nxt  = S_GAP;
          ph_cnt_nxt = '0;
        end else begin
          ph_cnt_nxt = ph_cnt + PH_W'(1);
        end
      end
      S_GAP: begin
        if (ph_cnt == PH_W'(PLACE_HOLD - 1)) begin
          if (!deb[B_PLACE]) begin
            state_nxt  = S_IDLE;
            ph_cnt_nxt = '0;
          end
        end else begin
          ph_cnt_nxt = ph_cnt + PH_W'(1);
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        ph_cnt_nxt = '0;
      end
    endcase
  end

  // Place sequencer: outputs, computed from the next state so that they come out registered.
  always_comb begin
    place_nxt = (state_nxt == S_STROBE);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  // Movement is frozen while the sequencer is active and on the cycle a place press is taken.
  logic move_block;
  assign move_block = (state != S_IDLE) || rise[B_PLACE];

  // Per-axis auto-repeat: axis 0 = column (left/right), axis 1 = row (up/down).
  logic [1:0]       lvl_neg, lvl_pos, rise_neg, rise_pos;
  logic [1:0]       armed, armed_nxt, rate_ph, rate_ph_nxt;
  logic [1:0]       step_neg, step_pos;
  logic [REP_W-1:0] rep_cnt [2];
  logic [REP_W-1:0] rep_cnt_nxt [2];

  assign lvl_neg  = {deb[B_UP],    deb[B_LEFT]};
  assign lvl_pos  = {deb[B_DOWN],  deb[B_RIGHT]};
  assign rise_neg = {rise[B_UP],   rise[B_LEFT]};
  assign rise_pos = {rise[B_DOWN], rise[B_RIGHT]};

  always_comb begin
    armed_nxt   = armed;
    rate_ph_nxt = rate_ph;
    rep_cnt_nxt = rep_cnt;
    step_neg    = '0;
    step_pos    = '0;
    for (int a = 0; a < 2; a++) begin
      if (move_block || (lvl_neg[a] && lvl_pos[a])) begin
        armed_nxt[a]   = 1'b0;
        rate_ph_nxt[a] = 1'b0;
        rep_cnt_nxt[a] = '0;
      end else if (rise_neg[a] || rise_pos[a]) begin
        step_neg[a]    = rise_neg[a];
        step_pos[a]    = rise_pos[a];
        armed_nxt[a]   = 1'b1;
        rate_ph_nxt[a] = 1'b0;
        rep_cnt_nxt[a] = '0;
      end else if (armed[a] && (lvl_neg[a] || lvl_pos[a])) begin
        if (rep_cnt[a] == (rate_ph[a] ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1))) begin
          step_neg[a]    = lvl_neg[a];
          step_pos[a]    = lvl_pos[a];
          rate_ph_nxt[a] = 1'b1;
          rep_cnt_nxt[a] = '0;
        end else begin
          rep_cnt_nxt[a] = rep_cnt[a] + REP_W'(1);
        end
      end else begin
        armed_nxt[a]   = 1'b0;
        rate_ph_nxt[a] = 1'b0;
        rep_cnt_nxt[a] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= '0;
      rate_ph <= '0;
      for (int a = 0; a < 2; a++) rep_cnt[a] <= '0;
    end else begin
      armed   <= armed_nxt;
      rate_ph <= rate_ph_nxt;
      rep_cnt <= rep_cnt_nxt;
    end
  end

  // Cursor update: the index and its one-hot image move together. The one-hot
  // value steps by rotation and is never decoded from the index.
  logic [IW-1:0] col_nxt, row_nxt;
  logic [N-1:0]  x_nxt, y_nxt;

  always_comb begin
    col_nxt = cur_col;
    row_nxt = cur_row;
    x_nxt   = x;
    y_nxt   = y;
    if (step_neg[0] && (WRAP || cur_col != '0)) begin
      col_nxt = (cur_col == '0) ? IW'(N - 1) : cur_col - IW'(1);
      x_nxt   = {x[0], x[N-1:1]};
    end else if (step_pos[0] && (WRAP || cur_col != IW'(N - 1))) begin
      col_nxt = (cur_col == IW'(N - 1)) ? '0 : cur_col + IW'(1);
      x_nxt   = {x[N-2:0], x[N-1]};
    end
    if (step_neg[1] && (WRAP || cur_row != '0)) begin
      row_nxt = (cur_row == '0) ? IW'(N - 1) : cur_row - IW'(1);
      y_nxt   = {y[0], y[N-1:1]};
    end else if (step_pos[1] && (WRAP || cur_row != IW'(N - 1))) begin
      row_nxt = (cur_row == IW'(N - 1)) ? '0 : cur_row + IW'(1);
      y_nxt   = {y[N-2:0], y[N-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_col <= IW'(START_X);
      cur_row <= IW'(START_Y);
      x       <= N'(1) << START_X;
      y       <= N'(1) << START_Y;
    end else begin
      cur_col <= col_nxt;
      cur_row <= row_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
    end
  end

endmodule

// File: tb/tb_go_cursor_input.sv
// Randomised scoreboard bench for go_cursor_input. A cycle-level reference model
// written from the behavioural rules predicts the outputs after every clock edge.
// The monitor compares them one cycle behind the stimulus.
`timescale 1ns/1ps
module tb_go_cursor_input;

  localparam int D  = 4;
  localparam int RD = 16;
  localparam int RR = 4;
  localparam int H  = 2;
  localparam int SX = 9;
  localparam int SY = 9;

  // Button vector layout: {place, right, left, down, up}.
  localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LT = 5'b00100, RT = 5'b01000, PL = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_place = 1'b0;
  logic [18:0] x, y;
  logic        place, busy;
  logic [4:0]  cur_col, cur_row;

  always #5 clk = ~clk;

  go_cursor_input dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_place(btn_place),
    .x(x), .y(y), .place(place), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  typedef struct packed {
    logic [18:0] x;
    logic [18:0] y;
    logic [4:0]  col;
    logic [4:0]  row;
    logic        place;
    logic        busy;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state.
  logic [4:0] r1, r2;
  logic [4:0] hist[$];
  logic [4:0] m_deb, m_prev;
  bit         m_busy, m_place;
  int         cyc, s_start;
  bit         armed[2];
  int         t0[2];
  int         mpos[2];

  task automatic model_reset();
    r1 = '0; r2 = '0; hist.delete();
    m_deb = '0; m_prev = '0;
    m_busy = 0; m_place = 0; s_start = 0;
    for (int a = 0; a < 2; a++) begin armed[a] = 0; t0[a] = 0; end
    mpos[0] = SX; mpos[1] = SY;
  endtask

  function automatic int move(input int p, input int dir);
`ifdef GO_CURSOR_WRAP_EN
    return (p + dir + 19) % 19;
`else
    int q;
    q = p + dir;
    if (q < 0) q = 0;
    if (q > 18) q = 18;
    return q;
`endif
  endfunction

  // One active clock edge with the given raw buttons.
  task automatic model_edge(input logic [4:0] rawv);
    logic [4:0] samp, lvl, rs;
    bit start, blocked, all_diff;
    int nb, pb, dir, t;
    cyc++;
    samp = r2; r2 = r1; r1 = rawv;
    lvl = m_deb;
    rs  = m_deb & ~m_prev;
    m_prev = m_deb;
    // A level flips once the last D synced samples all disagree with it.
    hist.push_back(samp);
    if (hist.size() > D) void'(hist.pop_front());
    if (hist.size() == D) begin
      for (int b = 0; b < 5; b++) begin
        all_diff = 1;
        foreach (hist[i]) if (hist[i][b] == m_deb[b]) all_diff = 0;
        if (all_diff) m_deb[b] = ~m_deb[b];
      end
    end
    start   = !m_busy && rs[4];
    blocked = m_busy || start;
    if (m_busy) begin
      if (cyc >= s_start + 2 * H && !lvl[4]) m_busy = 0;
    end else if (start) begin
      m_busy = 1; s_start = cyc;
    end
    m_place = m_busy && (cyc < s_start + H);
    for (int a = 0; a < 2; a++) begin
      nb = (a == 0) ? 2 : 0;
      pb = nb + 1;
      dir = 0;
      if (blocked || (lvl[nb] && lvl[pb])) begin
        armed[a] = 0;
      end else if (rs[nb] || rs[pb]) begin
        dir = rs[pb] ? 1 : -1; armed[a] = 1; t0[a] = cyc;
      end else if (armed[a] && (lvl[nb] || lvl[pb])) begin
        t = cyc - t0[a];
        if (t == RD || (t > RD && (t - RD) % RR == 0)) dir = lvl[pb] ? 1 : -1;
      end else begin
        armed[a] = 0;
      end
      if (dir != 0) mpos[a] = move(mpos[a], dir);
    end
  endtask

  function automatic obs_t cur_exp();
    obs_t e;
    e.x = 19'(1) << mpos[0];
    e.y = 19'(1) << mpos[1];
    e.col = 5'(mpos[0]);
    e.row = 5'(mpos[1]);
    e.place = m_place;
    e.busy = m_busy;
    return e;
  endfunction

  task automatic set_btn(input logic [4:0] v);
    {btn_place, btn_right, btn_left, btn_down, btn_up} = v;
  endtask

  task automatic drive(input logic [4:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      set_btn(v);
      model_edge(v);
      exp_q.push_back(cur_exp());
    end
  endtask

  // Reset is held for two cycles, checked immediately, and released on a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (place !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_immediate: got place=%b busy=%b, want place=0 busy=0", place, busy);
    end
    exp_q.push_back(cur_exp());
    @(negedge clk);
    exp_q.push_back(cur_exp());
    @(negedge clk);
    rst_n = 1'b1;
    set_btn('0);
    model_edge('0);
    exp_q.push_back(cur_exp());
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {x, y, cur_col, cur_row, place, busy};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got x=%05h y=%05h col=%0d row=%0d place=%b busy=%b, want x=%05h y=%05h col=%0d row=%0d place=%b busy=%b",
                   $time, a.x, a.y, a.col, a.row, a.place, a.busy,
                   e.x, e.y, e.col, e.row, e.place, e.busy);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    logic [4:0] v, m;
    int dur;
    model_reset();
    cyc = 0;
    do_reset();
    drive('0, 4);
    // Bounce on right: alternating samples never satisfy the debounce.
    for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? RT : 5'b0, 1);
    drive(RT, 1);
    drive('0, 12);
    // Clean press, one step.
    drive(RT, D + 3);
    drive('0, 12);
    // Held down: initial step plus auto-repeat.
    drive(DN, 41);
    drive('0, 12);
    // Run the column into the left edge, then press left again.
    drive(LT, 120);
    drive('0, 10);
    drive(LT, 8);
    drive('0, 10);
    // Run the column into the right edge.
    drive(RT, 120);
    drive('0, 10);
    // Place held 30 cycles with up pressed during the strobe.
    drive(PL, 3);
    drive(PL | UP, 6);
    drive(PL, 21);
    drive('0, 15);
    // Diagonal hold and opposing-direction holds.
    drive(UP | LT, 30);
    drive('0, 10);
    drive(UP | DN, 30);
    drive('0, 10);
    drive(LT, 10);
    drive(LT | RT, 20);
    drive('0, 10);
    // Reset while the strobe is high.
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      drive(PL, 1);
      ok = m_place;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL strobe_reached: got place_expected=%b, want 1", ok);
    end
    do_reset();
    drive('0, 8);
    // Random segments, some with contact bounce.
    for (int s = 0; s < 70; s++) begin
      v = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) != 0) v[4] = 1'b0;
      dur = $urandom_range(1, 45);
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < dur; c++) begin
          m = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
          drive(v ^ m, 1);
        end
      end else begin
        drive(v, dur);
      end
    end
    drive('0, 20);
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
